// File: rtl/pifo_pop_responder.sv
// Pop-side front end for the PIFO: credit-gated per-tree pops, response FIFOs.
// Optional zero-wait response path when PIFO_POP_BYPASS_EN is defined.
module pifo_pop_responder #(
  parameter int LEVEL   = 4,
  parameter int PTW     = 8,
  parameter int POP_LAT = 2,
  parameter int DEPTH   = 4,
  parameter int CNTW    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic [LEVEL-1:0]     i_req_valid,
  output logic [LEVEL-1:0]     o_req_ready,
  output logic [LEVEL-1:0]     o_pifo_pop,
  input  logic [LEVEL-1:0]     i_pifo_push,
  input  logic [LEVEL*PTW-1:0] i_pifo_pop_data,
  input  logic [LEVEL-1:0]     i_task_fifo_full,
  output logic [LEVEL-1:0]     o_rsp_valid,
  input  logic [LEVEL-1:0]     i_rsp_ready,
  output logic [LEVEL*PTW-1:0] o_rsp_data,
  output logic [LEVEL-1:0]     o_occ_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + POP_LAT + 1);
  localparam logic [CNTW-1:0] OCC_MAX = '1;

`ifdef PIFO_POP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [CNTW-1:0]    occ_q  [LEVEL];
  logic [CNTW-1:0]    occ_d  [LEVEL];
  logic [POP_LAT-1:0] pipe_q [LEVEL];
  logic [POP_LAT-1:0] pipe_d [LEVEL];
  logic [PTW-1:0]     mem_q  [LEVEL][DEPTH];
  logic [PTW-1:0]     mem_d  [LEVEL][DEPTH];
  logic [AW-1:0]      wp_q   [LEVEL];
  logic [AW-1:0]      wp_d   [LEVEL];
  logic [AW-1:0]      rp_q   [LEVEL];
  logic [AW-1:0]      rp_d   [LEVEL];
  logic [CW-1:0]      cnt_q  [LEVEL];
  logic [CW-1:0]      cnt_d  [LEVEL];
  logic [LEVEL-1:0]   err_q;
  logic [LEVEL-1:0]   err_d;

  logic [SW-1:0]      infl   [LEVEL];
  logic [PTW-1:0]     din    [LEVEL];
  logic [LEVEL-1:0]   ready;
  logic [LEVEL-1:0]   pop;
  logic [LEVEL-1:0]   arrive;
  logic [LEVEL-1:0]   byp;
  logic [LEVEL-1:0]   wr;
  logic [LEVEL-1:0]   rd;

  always_comb begin
    occ_d      = occ_q;
    pipe_d     = pipe_q;
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ready      = '0;
    pop        = '0;
    arrive     = '0;
    byp        = '0;
    wr         = '0;
    rd         = '0;
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    for (int t = 0; t < LEVEL; t++) begin
      din[t]  = i_pifo_pop_data[t*PTW +: PTW];
      infl[t] = '0;
      for (int k = 0; k < POP_LAT; k++)
        infl[t] = infl[t] + SW'(pipe_q[t][k]);

      // Credit covers both queued entries and pops still in the PIFO pipe
      ready[t] = i_arst_n
               & (occ_q[t] != '0)
               & ~i_task_fifo_full[t]
               & ((SW'(cnt_q[t]) + infl[t]) < SW'(DEPTH));
      pop[t]    = i_req_valid[t] & ready[t];
      arrive[t] = pipe_q[t][POP_LAT-1];
      byp[t]    = BYP & arrive[t] & (cnt_q[t] == '0);

      o_rsp_valid[t] = i_arst_n & ((cnt_q[t] != '0) | byp[t]);
      if (i_arst_n) begin
        if (cnt_q[t] != '0)
          o_rsp_data[t*PTW +: PTW] = mem_q[t][rp_q[t]];
        else if (byp[t])
          o_rsp_data[t*PTW +: PTW] = din[t];
      end

      rd[t] = (cnt_q[t] != '0) & i_rsp_ready[t];
      wr[t] = arrive[t] & ~(byp[t] & i_rsp_ready[t]);

      pipe_d[t][0] = pop[t];
      for (int k = 1; k < POP_LAT; k++)
        pipe_d[t][k] = pipe_q[t][k-1];

      if (wr[t]) begin
        mem_d[t][wp_q[t]] = din[t];
        wp_d[t] = wp_q[t] + AW'(1);
      end
      if (rd[t])
        rp_d[t] = rp_q[t] + AW'(1);
      unique case ({wr[t], rd[t]})
        2'b10:   cnt_d[t] = cnt_q[t] + CW'(1);
        2'b01:   cnt_d[t] = cnt_q[t] - CW'(1);
        default: cnt_d[t] = cnt_q[t];
      endcase

      unique case ({i_pifo_push[t], pop[t]})
        2'b10: begin
          if (occ_q[t] == OCC_MAX)
            err_d[t] = 1'b1;
          else
            occ_d[t] = occ_q[t] + CNTW'(1);
        end
        2'b01:   occ_d[t] = occ_q[t] - CNTW'(1);
        default: occ_d[t] = occ_q[t];
      endcase
    end
  end

  assign o_req_ready = ready;
  assign o_pifo_pop  = pop;
  assign o_occ_err   = err_q;

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      for (int t = 0; t < LEVEL; t++) begin
        occ_q[t]  <= '0;
        pipe_q[t] <= '0;
        wp_q[t]   <= '0;
        rp_q[t]   <= '0;
        cnt_q[t]  <= '0;
      end
      err_q <= '0;
    end else begin
      occ_q  <= occ_d;
      pipe_q <= pipe_d;
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_pifo_pop_responder.sv
// Bench for pifo_pop_responder: sorted-queue PIFO model plus response scoreboard.
// Build with +define+PIFO_POP_BYPASS_EN to exercise the bypass path.
module tb_pifo_pop_responder;

  localparam int L = 4;
  localparam int W = 8;
`ifdef PIFO_POP_BYPASS_EN
  localparam int RLAT = 2;
`else
  localparam int RLAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [L-1:0]  req_valid, req_ready, pifo_pop, pifo_push;
  logic [L-1:0]  task_full, rsp_valid, rsp_ready, occ_err;
  logic [L*W-1:0] pop_data, rsp_data;

  always #5 clk = ~clk;

  pifo_pop_responder #(
    .LEVEL(L), .PTW(W), .POP_LAT(2), .DEPTH(4), .CNTW(8)
  ) dut (
    .i_clk           (clk),
    .i_arst_n        (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .o_pifo_pop      (pifo_pop),
    .i_pifo_push     (pifo_push),
    .i_pifo_pop_data (pop_data),
    .i_task_fifo_full(task_full),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_occ_err       (occ_err)
  );

  logic [W-1:0] pq     [L][$];
  logic [W-1:0] exp_q  [L][$];
  int           popc   [L][$];
  int           pops_n [L];
  logic [W-1:0] pd0 [L];
  logic [W-1:0] pd1 [L];
  logic [W-1:0] push_val [L];
  logic [W-1:0] mv;
  int           cyc = 0;
  int           mon_pc;
  bit           lat_chk = 1'b0;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(int t, logic [W-1:0] v);
    pifo_push[t] = 1'b1;
    push_val[t]  = v;
    tick();
    pifo_push[t] = 1'b0;
  endtask

  // PIFO model: pop returns the minimum, data appears two cycles later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int t = 0; t < L; t++) begin
      pd1[t] <= pd0[t];
      pd0[t] <= 8'hA5;
      if (!rst_n) begin
        pq[t].delete();
        popc[t].delete();
      end else begin
        if (pifo_pop[t]) begin
          mv = 8'hEE;
          if (pq[t].size() != 0) mv = pq[t].pop_front();
          pd0[t] <= mv;
          popc[t].push_back(cyc);
          pops_n[t] <= pops_n[t] + 1;
        end
        if (pifo_push[t]) begin
          pq[t].push_back(push_val[t]);
          pq[t].sort();
        end
      end
    end
  end

  always_comb begin
    pop_data = '0;
    for (int t = 0; t < L; t++) pop_data[t*W +: W] = pd1[t];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int t = 0; t < L; t++) begin
        if (rsp_valid[t] && rsp_ready[t]) begin
          if (exp_q[t].size() == 0) begin
            check($sformatf("rsp_extra_t%0d", t), 32'(rsp_valid[t]), 0);
          end else begin
            check($sformatf("rsp_data_t%0d", t),
                  32'(rsp_data[t*W +: W]), 32'(exp_q[t].pop_front()));
            if (popc[t].size() != 0) begin
              mon_pc = popc[t].pop_front();
              if (lat_chk) check("rsp_lat", cyc - mon_pc, RLAT);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base0, base1, base2;
    logic bad;
    for (int t = 0; t < L; t++) begin
      pops_n[t] = 0;
      push_val[t] = '0;
    end
    rst_n     = 1'b0;
    req_valid = '1;
    pifo_push = '0;
    task_full = '0;
    rsp_ready = '1;
    tick();
    tick();
    @(negedge clk);
    check("rst_pop",   32'(pifo_pop), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rspv",  32'(rsp_valid), 0);
    check("rst_rspd",  rsp_data, 0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_err", 32'(occ_err), 0);

    // 1: three back-to-back pops on tree 2, latency tracked
    lat_chk = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      push1(2, W'(v));
      exp_q[2].push_back(W'(v));
    end
    base2 = pops_n[2];
    req_valid[2] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t1_pop", 32'(pifo_pop[2]), 1);
      tick();
    end
    req_valid[2] = 1'b0;
    repeat (6) tick();
    lat_chk = 1'b0;
    @(negedge clk);
    check("t1_npops", pops_n[2] - base2, 3);
    check("t1_occ0",  32'(req_ready[2]), 0);
    check("t1_drain", exp_q[2].size(), 0);

    // 2: request on an empty tree
    tick();
    base0 = pops_n[0];
    bad = 1'b0;
    req_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      bad = bad | pifo_pop[0] | req_ready[0] | rsp_valid[0];
      tick();
    end
    req_valid[0] = 1'b0;
    check("t2_blocked", 32'(bad), 0);
    check("t2_npops", pops_n[0] - base0, 0);

    // 3: credit limit with a stalled consumer
    rsp_ready[0] = 1'b0;
    for (int v = 1; v <= 7; v++) begin
      push1(0, W'(v));
      exp_q[0].push_back(W'(v));
    end
    base0 = pops_n[0];
    req_valid[0] = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("t3_pops4", pops_n[0] - base0, 4);
    check("t3_rdy0",  32'(req_ready[0]), 0);
    check("t3_hold_v", 32'(rsp_valid[0]), 1);
    check("t3_hold_d", 32'(rsp_data[W-1:0]), 1);
    tick();
    rsp_ready[0] = 1'b1;
    repeat (20) tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t3_pops7", pops_n[0] - base0, 7);
    check("t3_drain", exp_q[0].size(), 0);
    check("t3_occ0",  32'(req_ready[0]), 0);
    tick();

    // 4: interleaved trees, then push+pop on tree 0 in one cycle
    for (int v = 1; v <= 3; v++) begin
      push1(2, W'(v));
      exp_q[2].push_back(W'(v));
    end
    base0 = pops_n[0];
    base2 = pops_n[2];
    for (int i = 0; i < 3; i++) begin
      push1(0, W'(8 + i));
      req_valid[2] = 1'b1;
      tick();
      req_valid[2] = 1'b0;
    end
    repeat (6) tick();
    @(negedge clk);
    check("t4_t2pops",  pops_n[2] - base2, 3);
    check("t4_t2drain", exp_q[2].size(), 0);
    check("t4_t0pops",  pops_n[0] - base0, 0);
    check("t4_t0rdy",   32'(req_ready[0]), 1);
    tick();
    for (int v = 8; v <= 11; v++) exp_q[0].push_back(W'(v));
    pifo_push[0] = 1'b1;
    push_val[0]  = 8'd11;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t4_pp_pop", 32'(pifo_pop[0]), 1);
    tick();
    pifo_push[0] = 1'b0;
    repeat (12) tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("t4_t0total", pops_n[0] - base0, 4);
    check("t4_t0drain", exp_q[0].size(), 0);
    check("t4_iso", 32'({rsp_valid[1], rsp_valid[3],
                         req_ready[1], req_ready[3]}), 0);
    tick();

    // 5: task FIFO full blocks only its own tree
    push1(1, 8'd20);
    push1(1, 8'd21);
    push1(2, 8'd30);
    exp_q[1].push_back(8'd20);
    exp_q[1].push_back(8'd21);
    exp_q[2].push_back(8'd30);
    base1 = pops_n[1];
    base2 = pops_n[2];
    task_full[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("t5_blk_pops", pops_n[1] - base1, 0);
    check("t5_blk_rdy",  32'(req_ready[1]), 0);
    check("t5_t2pop",    pops_n[2] - base2, 1);
    tick();
    task_full[1] = 1'b0;
    @(negedge clk);
    check("t5_resume", 32'(pifo_pop[1]), 1);
    repeat (5) tick();
    req_valid = '0;
    repeat (4) tick();
    @(negedge clk);
    check("t5_pops", pops_n[1] - base1, 2);
    check("t5_drain", exp_q[1].size() + exp_q[2].size(), 0);
    tick();

    // 6: reset while pops are in flight
    push1(0, 8'd40);
    push1(0, 8'd41);
    push1(0, 8'd42);
    base0 = pops_n[0];
    req_valid[0] = 1'b1;
    tick();
    tick();
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_pop",  32'(pifo_pop), 0);
    check("t6_rdy",  32'(req_ready), 0);
    check("t6_rspv", 32'(rsp_valid), 0);
    check("t6_rspd", rsp_data, 0);
    tick();
    rst_n = 1'b1;
    check("t6_npops", pops_n[0] - base0, 2);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bad = bad | (|rsp_valid) | req_ready[0];
      tick();
    end
    check("t6_quiet", 32'(bad), 0);
    check("t6_err",   32'(occ_err), 0);

    // occupancy saturation on tree 3
    for (int i = 0; i < 255; i++) push1(3, W'(i));
    @(negedge clk);
    check("sat_noerr", 32'(occ_err), 0);
    tick();
    push1(3, 8'hFF);
    @(negedge clk);
    check("sat_err", 32'(occ_err), 32'h8);
    check("sb_left", exp_q[0].size() + exp_q[1].size()
                   + exp_q[2].size() + exp_q[3].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
